// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants, tick divisor.
// No logic, no latency, no flow control.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Clocks per oversample tick, truncated; never below 1 so the tick generator stays legal.
  function automatic int tick_div(input int clk_freq, input int baud_rate);
    int d;
    d = clk_freq / (baud_rate * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Free-running 16x oversample tick: one-cycle TICK_16X every DIV clocks.
// Tick is combinational from the counter; no backpressure.
module baud_gen_rx #(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK_16X
);

  localparam logic [26:0] DIV_M1 = 27'(DIV - 1);

  logic [26:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (cnt == DIV_M1) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 27'd1;
    end
  end

  assign TICK_16X = (cnt == DIV_M1);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled with 3-sample centre vote; RX_VALID 1 clk after stop-bit s=9 tick.
// No backpressure: RX_DATA is held only until the next good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int          DIV      = tick_div(CLK_FREQ, BAUD_RATE);
  localparam int          BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]  S_MID    = 4'(MID_SAMPLE);
  localparam logic [3:0]  S_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic tick;

  baud_gen_rx #(
    .DIV(DIV)
  ) u_baud_gen (
    .CLK     (CLK),
    .RST     (RST),
    .TICK_16X(tick)
  );

  // Two-flop synchroniser; everything downstream looks at rxd_s only.
  logic rxd_m, rxd_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RXD;
      rxd_s <= rxd_m;
    end
  end

  rx_state_t            state, state_nxt;
  logic [3:0]           s_cnt, s_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 smp7, smp7_nxt;
  logic                 smp8, smp8_nxt;
  logic                 valid_q, valid_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 vote;

  // Samples 7 and 8 are latched; sample 9 is the live rxd_s on the deciding tick.
  assign vote = (smp7 & smp8) | (smp7 & rxd_s) | (smp8 & rxd_s);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      s_cnt   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      smp7    <= 1'b0;
      smp8    <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_cnt   <= s_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      data_q  <= data_nxt;
      smp7    <= smp7_nxt;
      smp8    <= smp8_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    smp7_nxt  = smp7;
    smp8_nxt  = smp8;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    if (tick) begin
      if (state != ST_IDLE) begin
        s_nxt = s_cnt + 4'd1;
        if (s_cnt == 4'd7) smp7_nxt = rxd_s;
        if (s_cnt == 4'd8) smp8_nxt = rxd_s;
      end

      unique case (state)
        ST_IDLE: begin
          // The detecting tick is sample 0, so the next tick is sample 1.
          if (!rxd_s) begin
            state_nxt = ST_START;
            s_nxt     = 4'd1;
          end
        end
        ST_START: begin
          if (s_cnt == S_MID && vote) begin
            state_nxt = ST_IDLE;
            s_nxt     = '0;
          end else if (s_cnt == S_LAST) begin
            state_nxt = ST_DATA;
            s_nxt     = '0;
            bit_nxt   = '0;
          end
        end
        ST_DATA: begin
          if (s_cnt == S_MID) shreg_nxt[bit_cnt] = vote;
          if (s_cnt == S_LAST) begin
            s_nxt = '0;
            if (bit_cnt == BIT_LAST) state_nxt = ST_STOP;
            else                     bit_nxt   = bit_cnt + BW'(1);
          end
        end
        ST_STOP: begin
          // Decide at mid stop bit so a following start edge is not missed.
          if (s_cnt == S_MID) begin
            state_nxt = ST_IDLE;
            s_nxt     = '0;
            if (vote) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
            end else begin
              ferr_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state != ST_IDLE);

endmodule
